// File: rtl/ip_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_sel_ctrl_pkg
// Brief    : Shared FSM encoding, register map and STATUS layout for ip_sel_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package ip_sel_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUIESCE = 3'd1,
      ST_RESET   = 3'd2,
      ST_SWITCH  = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_ABORT   = 3'd5
   } state_e;

   localparam logic [3:0] c_addr_req    = 4'h0;
   localparam logic [3:0] c_addr_status = 4'h4;
   localparam logic [3:0] c_addr_tmo    = 4'h8;
   localparam logic [3:0] c_addr_irqen  = 4'hC;

   localparam int c_stat_busy    = 0;
   localparam int c_stat_done    = 1;
   localparam int c_stat_err     = 2;
   localparam int c_stat_sel_lsb = 8;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ip_sel_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : ip_sel_ctrl_regs
// Brief    : Config APB decode and register file (REQ/STATUS/TMO, IRQEN when
//            IP_SEL_CTRL_IRQ_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module ip_sel_ctrl_regs #(
   parameter int unsigned   SEL_WIDTH = 5,
   parameter logic [15:0]   DEF_TMO   = 16'd1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_psel_i,
   input  logic                 cfg_penable_i,
   input  logic                 cfg_pwrite_i,
   input  logic [3:0]           cfg_paddr_i,
   input  logic [31:0]          cfg_pwdata_i,
   output logic [31:0]          cfg_prdata_o,
   output logic                 cfg_pslverr_o,
   input  logic                 busy_i,
   input  logic [SEL_WIDTH-1:0] sel_i,
   input  logic                 set_done_i,
   input  logic                 set_err_i,
   output logic                 req_start_o,
   output logic [SEL_WIDTH-1:0] target_o,
   output logic [15:0]          tmo_o,
   output logic                 irq_o
);
   import ip_sel_ctrl_pkg::*;

   logic [SEL_WIDTH-1:0] target_q, target_d;
   logic [15:0]          tmo_q, tmo_d;
   logic                 done_q, done_d, err_q, err_d;
   logic [31:0]          prdata_q, prdata_d;

   logic                 w_access, w_setup, w_is_req, w_is_status, w_is_tmo, w_is_irqen;
   logic                 w_mapped, w_req_wr, w_req_ok, w_stat_wr;
   logic [3:0]           w_addr;
   logic [SEL_WIDTH-1:0] w_new_sel;
   logic [1:0]           w_irqen_rd;
   logic [31:0]          w_status, w_rdata;
   logic                 unused_bits;

   assign w_access    = cfg_psel_i & cfg_penable_i;
   assign w_setup     = cfg_psel_i & ~cfg_penable_i;
   assign w_addr      = {cfg_paddr_i[3:2], 2'b00};
   assign w_is_req    = (w_addr == c_addr_req);
   assign w_is_status = (w_addr == c_addr_status);
   assign w_is_tmo    = (w_addr == c_addr_tmo);
   assign w_mapped    = w_is_req | w_is_status | w_is_tmo | w_is_irqen;
   assign w_new_sel   = cfg_pwdata_i[SEL_WIDTH-1:0];
   assign w_req_wr    = w_access & cfg_pwrite_i & w_is_req;
   assign w_req_ok    = w_req_wr & ~busy_i;
   assign w_stat_wr   = w_access & cfg_pwrite_i & w_is_status;
   assign unused_bits = ^{cfg_paddr_i[1:0], cfg_pwdata_i[31:16]};

   // Error is decided in the access cycle from the same busy that gates acceptance.
   assign req_start_o   = w_req_ok & (w_new_sel != sel_i);
   assign cfg_pslverr_o = w_access & (~w_mapped | (w_req_wr & busy_i));
   assign cfg_prdata_o  = prdata_q;
   assign target_o      = target_q;
   assign tmo_o         = tmo_q;

   always_comb begin
      w_status                          = '0;
      w_status[c_stat_busy]             = busy_i;
      w_status[c_stat_done]             = done_q;
      w_status[c_stat_err]              = err_q;
      w_status[c_stat_sel_lsb +: 8]     = 8'(sel_i);

      w_rdata = '0;
      if (w_is_req)         w_rdata = 32'(target_q);
      else if (w_is_status) w_rdata = w_status;
      else if (w_is_tmo)    w_rdata = {16'h0000, tmo_q};
      else if (w_is_irqen)  w_rdata = {30'h0, w_irqen_rd};
   end

   always_comb begin
      target_d = w_req_ok ? w_new_sel : target_q;
      tmo_d    = (w_access & cfg_pwrite_i & w_is_tmo) ? cfg_pwdata_i[15:0] : tmo_q;

      // Clear first so a coincident set wins.
      done_d = done_q;
      if (w_stat_wr & cfg_pwdata_i[c_stat_done]) done_d = 1'b0;
      if (set_done_i | (w_req_ok & (w_new_sel == sel_i))) done_d = 1'b1;

      err_d = err_q;
      if (w_stat_wr & cfg_pwdata_i[c_stat_err]) err_d = 1'b0;
      if (set_err_i) err_d = 1'b1;

      prdata_d = w_setup ? w_rdata : prdata_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         target_q <= '0;
         tmo_q    <= DEF_TMO;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         prdata_q <= '0;
      end else begin
         target_q <= target_d;
         tmo_q    <= tmo_d;
         done_q   <= done_d;
         err_q    <= err_d;
         prdata_q <= prdata_d;
      end
   end

`ifdef IP_SEL_CTRL_IRQ_EN
   logic [1:0] irqen_q, irqen_d;
   logic       irq_q, irq_d;

   assign w_is_irqen = (w_addr == c_addr_irqen);
   assign w_irqen_rd = irqen_q;
   assign irq_o      = irq_q;

   always_comb begin
      irqen_d = irqen_q;
      if (w_access & cfg_pwrite_i & w_is_irqen) irqen_d = cfg_pwdata_i[1:0];
      irq_d = (done_q & irqen_q[0]) | (err_q & irqen_q[1]);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irqen_q <= 2'b00;
         irq_q   <= 1'b0;
      end else begin
         irqen_q <= irqen_d;
         irq_q   <= irq_d;
      end
   end
`else
   assign w_is_irqen = 1'b0;
   assign w_irqen_rd = 2'b00;
   assign irq_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/ip_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ip_sel_ctrl
// Brief    : Glitch-free runtime switching of the user-IP select code: quiesce,
//            drain, reset user IP, update sel_o, settle. IRQ via IP_SEL_CTRL_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ip_sel_ctrl #(
   parameter int unsigned SEL_WIDTH     = 5,
   parameter int unsigned RST_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] DEF_TMO       = 16'd1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_psel_i,
   input  logic                 cfg_penable_i,
   input  logic                 cfg_pwrite_i,
   input  logic [3:0]           cfg_paddr_i,
   input  logic [31:0]          cfg_pwdata_i,
   output logic [31:0]          cfg_prdata_o,
   output logic                 cfg_pready_o,
   output logic                 cfg_pslverr_o,
   input  logic                 bus_psel_i,
   input  logic                 bus_penable_i,
   input  logic                 bus_pready_i,
   output logic                 bus_hold_o,
   output logic                 ip_rst_o,
   output logic [SEL_WIDTH-1:0] sel_o,
   output logic                 busy_o,
   output logic                 irq_o
);
   import ip_sel_ctrl_pkg::*;

   localparam logic [15:0] c_rst_last    = 16'(RST_CYCLES - 1);
   localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);

   state_e               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d, tmo_act_q, tmo_act_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 hold_q, hold_d, iprst_q, iprst_d, busy_q, busy_d;

   logic                 w_req_start, w_set_done, w_set_err, w_slot_idle;
   logic [SEL_WIDTH-1:0] w_target;
   logic [15:0]          w_tmo;

   ip_sel_ctrl_regs #(
      .SEL_WIDTH (SEL_WIDTH),
      .DEF_TMO   (DEF_TMO)
   ) u_regs (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cfg_psel_i    (cfg_psel_i),
      .cfg_penable_i (cfg_penable_i),
      .cfg_pwrite_i  (cfg_pwrite_i),
      .cfg_paddr_i   (cfg_paddr_i),
      .cfg_pwdata_i  (cfg_pwdata_i),
      .cfg_prdata_o  (cfg_prdata_o),
      .cfg_pslverr_o (cfg_pslverr_o),
      .busy_i        (busy_q),
      .sel_i         (sel_q),
      .set_done_i    (w_set_done),
      .set_err_i     (w_set_err),
      .req_start_o   (w_req_start),
      .target_o      (w_target),
      .tmo_o         (w_tmo),
      .irq_o         (irq_o)
   );

   // A completing transfer counts as idle: the slot is free from the next cycle.
   assign w_slot_idle = ~bus_psel_i | (bus_penable_i & bus_pready_i);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_act_d  = tmo_act_q;
      sel_d      = sel_q;
      w_set_done = 1'b0;
      w_set_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_req_start) begin
               state_d   = ST_QUIESCE;
               cnt_d     = '0;
               tmo_act_d = w_tmo;
            end
         end
         ST_QUIESCE: begin
            if (w_slot_idle) begin
               state_d = ST_RESET;
               cnt_d   = '0;
            end else if ((tmo_act_q != 16'd0) && (sat_inc16(cnt_q) >= tmo_act_q)) begin
               state_d = ST_ABORT;
            end else begin
               cnt_d = sat_inc16(cnt_q);
            end
         end
         ST_RESET: begin
            if (cnt_q == c_rst_last) begin
               state_d = ST_SWITCH;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc16(cnt_q);
            end
         end
         ST_SWITCH: begin
            sel_d   = w_target;
            state_d = ST_SETTLE;
            cnt_d   = '0;
         end
         ST_SETTLE: begin
            if (cnt_q == c_settle_last) begin
               state_d    = ST_IDLE;
               w_set_done = 1'b1;
            end else begin
               cnt_d = sat_inc16(cnt_q);
            end
         end
         ST_ABORT: begin
            state_d   = ST_IDLE;
            w_set_err = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d  = (state_d != ST_IDLE);
      hold_d  = (state_d == ST_QUIESCE) || (state_d == ST_RESET) ||
                (state_d == ST_SWITCH)  || (state_d == ST_SETTLE);
      iprst_d = (state_d == ST_RESET);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         tmo_act_q <= DEF_TMO;
         sel_q     <= '0;
         hold_q    <= 1'b0;
         iprst_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmo_act_q <= tmo_act_d;
         sel_q     <= sel_d;
         hold_q    <= hold_d;
         iprst_q   <= iprst_d;
         busy_q    <= busy_d;
      end
   end

   assign cfg_pready_o = 1'b1;
   assign bus_hold_o   = hold_q;
   assign ip_rst_o     = iprst_q;
   assign sel_o        = sel_q;
   assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_sel_ctrl
// Brief    : Directed self-checking bench for ip_sel_ctrl (IRQ path checked
//            when IP_SEL_CTRL_IRQ_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_sel_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [3:0]  paddr = 4'h0;
   logic [31:0] pwdata = 32'h0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        bpsel = 1'b0, bpenable = 1'b0, bpready = 1'b0;
   logic        hold, iprst, busy, irq;
   logic [4:0]  sel;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] rd;
   logic        e;
   int          n_hold, n_rst, n_busy, n_bad;

   ip_sel_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .cfg_psel_i    (psel),
      .cfg_penable_i (penable),
      .cfg_pwrite_i  (pwrite),
      .cfg_paddr_i   (paddr),
      .cfg_pwdata_i  (pwdata),
      .cfg_prdata_o  (prdata),
      .cfg_pready_o  (pready),
      .cfg_pslverr_o (pslverr),
      .bus_psel_i    (bpsel),
      .bus_penable_i (bpenable),
      .bus_pready_i  (bpready),
      .bus_hold_o    (hold),
      .ip_rst_o      (iprst),
      .sel_o         (sel),
      .busy_o        (busy),
      .irq_o         (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] data, output logic err);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      data = prdata;
      err  = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   // Count outputs over a window starting at the current cycle.
   task automatic observe(input int cycles);
      n_hold = 0; n_rst = 0; n_busy = 0; n_bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (hold)  n_hold++;
         if (iprst) n_rst++;
         if (busy)  n_busy++;
         if (iprst && sel != 5'd0) n_bad++;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sel", sel, 0);
      chk("rst_hold", hold, 0);
      chk("rst_iprst", iprst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_irq", irq, 0);
      chk("rst_prdata", prdata, 0);
      chk("rst_pslverr", pslverr, 0);
      chk("pready", pready, 1);
      @(posedge clk); #1 rst = 1'b0;

      apb(1'b0, 4'h8, 0, rd, e);
      chk("tmo_reset", rd, 32'd1024);
      apb(1'b0, 4'h4, 0, rd, e);
      chk("status_reset", rd, 32'h0);

      // Full switch 0 -> 3 with idle slot
      apb(1'b1, 4'h0, 32'h3, rd, e);
      chk("req3_err", e, 0);
      observe(12);
      chk("req3_hold_cycles", n_hold, 8);
      chk("req3_rst_cycles", n_rst, 4);
      chk("req3_busy_cycles", n_busy, 8);
      chk("req3_sel_during_rst", n_bad, 0);
      chk("req3_sel", sel, 3);
      apb(1'b0, 4'h4, 0, rd, e);
      chk("req3_status", rd, 32'h0302);
      apb(1'b0, 4'h0, 0, rd, e);
      chk("req3_target", rd, 32'h3);

      // W1C done, then same-target request
      apb(1'b1, 4'h4, 32'h2, rd, e);
      apb(1'b0, 4'h4, 0, rd, e);
      chk("w1c_done", rd, 32'h0300);
      apb(1'b1, 4'h0, 32'h3, rd, e);
      chk("same_err", e, 0);
      observe(6);
      chk("same_hold", n_hold, 0);
      chk("same_rst", n_rst, 0);
      apb(1'b0, 4'h4, 0, rd, e);
      chk("same_status", rd, 32'h0302);

      // Drain: slot in wait state for 10 QUIESCE cycles
      apb(1'b1, 4'h8, 32'd100, rd, e);
      bpsel = 1'b1; bpenable = 1'b1; bpready = 1'b0;
      apb(1'b1, 4'h0, 32'h5, rd, e);
      observe(10);
      chk("drain_no_rst", n_rst, 0);
      chk("drain_hold", n_hold, 10);
      bpready = 1'b1;
      @(posedge clk); #1;
      bpsel = 1'b0; bpenable = 1'b0; bpready = 1'b0;
      @(negedge clk);
      chk("drain_rst_rise", iprst, 1);
      chk("drain_sel_old", sel, 3);
      wait_idle("drain_timeout");
      chk("drain_sel_new", sel, 5);

      // Timeout abort with TMO=5
      apb(1'b1, 4'h4, 32'h6, rd, e);
      apb(1'b1, 4'h8, 32'd5, rd, e);
      bpsel = 1'b1; bpenable = 1'b1; bpready = 1'b0;
      apb(1'b1, 4'h0, 32'h7, rd, e);
      observe(12);
      chk("abort_hold", n_hold, 5);
      chk("abort_busy", n_busy, 6);
      chk("abort_no_rst", n_rst, 0);
      chk("abort_sel", sel, 5);
      bpsel = 1'b0; bpenable = 1'b0;
      apb(1'b0, 4'h4, 0, rd, e);
      chk("abort_status", rd, 32'h0504);
      apb(1'b1, 4'h4, 32'h4, rd, e);
      apb(1'b0, 4'h4, 0, rd, e);
      chk("abort_w1c", rd, 32'h0500);

      // REQ while busy is rejected
      apb(1'b1, 4'h0, 32'h1, rd, e);
      apb(1'b1, 4'h0, 32'h9, rd, e);
      chk("busy_req_err", e, 1);
      wait_idle("busy_timeout");
      apb(1'b0, 4'h0, 0, rd, e);
      chk("busy_target", rd, 32'h1);
      chk("busy_sel", sel, 1);

`ifndef IP_SEL_CTRL_IRQ_EN
      apb(1'b0, 4'hC, 0, rd, e);
      chk("unmapped_data", rd, 0);
      chk("unmapped_err", e, 1);
`endif

      // Reset in the middle of RESET
      apb(1'b1, 4'h0, 32'h2, rd, e);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_in_reset", iprst, 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_sel", sel, 0);
      chk("mid_iprst", iprst, 0);
      chk("mid_hold", hold, 0);
      chk("mid_busy", busy, 0);
      apb(1'b0, 4'h8, 0, rd, e);
      chk("mid_tmo", rd, 32'd1024);
      apb(1'b0, 4'h4, 0, rd, e);
      chk("mid_status", rd, 0);

`ifdef IP_SEL_CTRL_IRQ_EN
      apb(1'b1, 4'hC, 32'h1, rd, e);
      apb(1'b0, 4'hC, 0, rd, e);
      chk("irqen_rd", rd, 32'h1);
      apb(1'b1, 4'h0, 32'h0, rd, e);
      @(negedge clk);
      chk("irq_lag", irq, 0);
      @(negedge clk);
      chk("irq_rise", irq, 1);
`else
      chk("irq_tied", irq, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
